// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM round-robin arbiter:
// FSM states, default widths, port index type, last_grant reset value.
package ram_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef logic port_idx_t;

  // Reset to port 1 so that port 0 wins the first tie after reset.
  localparam port_idx_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// One requester's command/response bundle. The requester drives it
// through the master modport; the arbiter serves it through the slave modport.
interface ram_rr_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/ram_rr_arbiter_rr_pick2.sv
// Combinational two-way winner select. Round-robin on ties by default;
// defining ARB_FIXED_PRIO_EN makes port 0 always win ties.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t last_grant,
  output logic      valid,
  output port_idx_t winner
);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant;
`endif
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous RAM (1-cycle
// read latency). Optional ARB_FIXED_PRIO_EN switches ties to fixed priority.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_rr_arbiter_if.slave port0,
  ram_rr_arbiter_if.slave port1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  state_t    state;
  port_idx_t sel;
  port_idx_t last_grant;
  logic      is_read;
  logic      grant_valid;
  port_idx_t winner;

  rr_pick2 u_pick (
    .req0       (port0.req),
    .req1       (port1.req),
    .last_grant (last_grant),
    .valid      (grant_valid),
    .winner     (winner)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= 1'b0;
      last_grant  <= LAST_GRANT_RST;
      is_read     <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_wren    <= 1'b0;
      busy        <= 1'b0;
      port0.ack   <= 1'b0;
      port1.ack   <= 1'b0;
      port0.rdata <= '0;
      port1.rdata <= '0;
    end else begin
      port0.ack <= 1'b0;
      port1.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            sel        <= winner;
            last_grant <= winner;
            if (winner) begin
              ram_addr <= port1.addr;
              ram_din  <= port1.wdata;
              ram_wren <= port1.we;
              is_read  <= ~port1.we;
            end else begin
              ram_addr <= port0.addr;
              ram_din  <= port0.wdata;
              ram_wren <= port0.we;
              is_read  <= ~port0.we;
            end
            busy  <= 1'b1;
            state <= ISSUE;
          end else begin
            ram_wren <= 1'b0;
          end
        end
        ISSUE: begin
          // RAM captures the command on this edge; the write pulse ends here.
          ram_wren <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          if (sel) begin
            port1.ack <= 1'b1;
            if (is_read) port1.rdata <= ram_q;
          end else begin
            port0.ack <= 1'b1;
            if (is_read) port0.rdata <= ram_q;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_wren <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural 256x8 synchronous RAM.
// Compile with +define+ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_ram_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_wren;
  logic [7:0] ram_q;
  logic       busy;

  int vectors = 0;
  int errors  = 0;
  bit both_ack = 1'b0;

  ram_rr_arbiter_if #(.AW(8), .DW(8)) p0 ();
  ram_rr_arbiter_if #(.AW(8), .DW(8)) p1 ();

  ram_rr_arbiter #(.AW(8), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .port0    (p0),
    .port1    (p1),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_wren (ram_wren),
    .ram_q    (ram_q),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  always @(posedge clk) begin
    #1;
    if (p0.ack && p1.ack) both_ack = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  task automatic drive(input int port, input logic r, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    if (port == 0) begin
      p0.req = r; p0.we = we; p0.addr = a; p0.wdata = d;
    end else begin
      p1.req = r; p1.we = we; p1.addr = a; p1.wdata = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one access and wait for its ack; edges counts from the grant edge.
  task automatic access(input int port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, output int edges,
                        output int wren_cycles, output logic [7:0] rd);
    logic got;
    got = 1'b0; edges = 0; wren_cycles = 0; rd = 8'h00;
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    while (!got && edges < 12) begin
      @(posedge clk); #1;
      edges++;
      if (ram_wren) wren_cycles++;
      if (port == 0 && p0.ack) begin got = 1'b1; rd = p0.rdata; end
      if (port == 1 && p1.ack) begin got = 1'b1; rd = p1.rdata; end
    end
    drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
    if (!got) begin
      vectors++; errors++;
      $display("FAIL access_timeout port%0d: no ack after %0d edges, expected ack", port, edges);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ram_wren, busy, p0.ack, p1.ack} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: wren/busy/ack0/ack1=%b, expected 0000", {ram_wren, busy, p0.ack, p1.ack});
    end
    vectors++;
    if ({ram_addr, ram_din} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ram_bus: addr/din=%h, expected 0000", {ram_addr, ram_din});
    end
    vectors++;
    if ({p0.rdata, p1.rdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: rdata0/rdata1=%h, expected 0000", {p0.rdata, p1.rdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int e, w;
    logic [7:0] rd;
    access(0, 1'b1, 8'h10, 8'hA5, e, w, rd);
    vectors++;
    if (e !== 3) begin errors++; $display("FAIL wr_latency: %0d edges, expected 3", e); end
    vectors++;
    if (w !== 1) begin errors++; $display("FAIL wr_wren_width: %0d cycles, expected 1", w); end
    @(posedge clk); #1;
    vectors++;
    if (p0.ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: ack0=%b one cycle later, expected 0", p0.ack); end
    access(0, 1'b0, 8'h10, 8'h00, e, w, rd);
    vectors++;
    if (e !== 3) begin errors++; $display("FAIL rd_latency: %0d edges, expected 3", e); end
    vectors++;
    if (w !== 0) begin errors++; $display("FAIL rd_wren: %0d cycles, expected 0", w); end
    vectors++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL rd_data: rdata0=%h, expected a5", rd); end
  endtask

  task automatic test_simultaneous();
    int e, w, a0_edge, a1_edge;
    logic [7:0] rd;
    do_reset();
    a0_edge = 0; a1_edge = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h01, 8'h11);
    drive(1, 1'b1, 1'b1, 8'h02, 8'h22);
    for (int i = 1; i <= 12 && (a0_edge == 0 || a1_edge == 0); i++) begin
      @(posedge clk); #1;
      if (p0.ack) begin a0_edge = i; drive(0, 1'b0, 1'b0, 8'h00, 8'h00); end
      if (p1.ack) begin a1_edge = i; drive(1, 1'b0, 1'b0, 8'h00, 8'h00); end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    vectors++;
    if (a0_edge !== 3) begin errors++; $display("FAIL sim_first_ack0: edge %0d, expected 3", a0_edge); end
    vectors++;
    if (a1_edge !== 6) begin errors++; $display("FAIL sim_second_ack1: edge %0d, expected 6", a1_edge); end
    access(1, 1'b0, 8'h01, 8'h00, e, w, rd);
    vectors++;
    if (rd !== 8'h11) begin errors++; $display("FAIL sim_readback01: %h, expected 11", rd); end
    access(0, 1'b0, 8'h02, 8'h00, e, w, rd);
    vectors++;
    if (rd !== 8'h22) begin errors++; $display("FAIL sim_readback02: %h, expected 22", rd); end
  endtask

  task automatic test_fairness();
    int n_ack, busy_low;
    int seq [6];
    logic [7:0] rd_seen [6];
    do_reset();
    n_ack = 0; busy_low = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int i = 1; i <= 30 && n_ack < 6; i++) begin
      @(posedge clk); #1;
      if (!busy) busy_low++;
      if (p0.ack) begin seq[n_ack] = 0; rd_seen[n_ack] = p0.rdata; n_ack++; end
      else if (p1.ack) begin seq[n_ack] = 1; rd_seen[n_ack] = p1.rdata; n_ack++; end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    vectors++;
    if (n_ack !== 6) begin errors++; $display("FAIL fair_count: %0d acks, expected 6", n_ack); end
    for (int k = 0; k < n_ack; k++) begin
      vectors++;
      if (seq[k] !== (k % 2)) begin
        errors++; $display("FAIL fair_order[%0d]: port%0d, expected port%0d", k, seq[k], k % 2);
      end
      vectors++;
      if (rd_seen[k] !== ((k % 2) ? 8'h22 : 8'hA5)) begin
        errors++; $display("FAIL fair_rdata[%0d]: %h, expected %h", k, rd_seen[k], (k % 2) ? 8'h22 : 8'hA5);
      end
    end
    vectors++;
    if (busy_low !== 6) begin errors++; $display("FAIL fair_busy_gap: %0d idle cycles, expected 6", busy_low); end
    vectors++;
    if (both_ack !== 1'b0) begin errors++; $display("FAIL fair_exclusive_ack: both acks seen=%b, expected 0", both_ack); end
  endtask

  task automatic test_isolation();
    int e, w;
    logic [7:0] rd;
    access(1, 1'b1, 8'hFF, 8'h3C, e, w, rd);
    access(0, 1'b1, 8'h20, 8'h55, e, w, rd);
    access(0, 1'b0, 8'h20, 8'h00, e, w, rd);
    vectors++;
    if (p0.rdata !== 8'h55) begin errors++; $display("FAIL iso_setup: rdata0=%h, expected 55", p0.rdata); end
    access(1, 1'b0, 8'hFF, 8'h00, e, w, rd);
    vectors++;
    if (rd !== 8'h3C) begin errors++; $display("FAIL iso_rdata1: %h, expected 3c", rd); end
    vectors++;
    if (p0.rdata !== 8'h55) begin errors++; $display("FAIL iso_rdata0_held: %h, expected 55", p0.rdata); end
  endtask

  task automatic test_reset_mid();
    int acks, first_port;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h30, 8'h77);
    @(posedge clk); #1;
    vectors++;
    if ({busy, ram_wren} !== 2'b11) begin errors++; $display("FAIL mid_issue: busy/wren=%b, expected 11", {busy, ram_wren}); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, ram_wren} !== 2'b00) begin errors++; $display("FAIL mid_abort: busy/wren=%b, expected 00", {busy, ram_wren}); end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (p0.ack || p1.ack) acks++;
    end
    vectors++;
    if (acks !== 0) begin errors++; $display("FAIL mid_no_ack: %0d acks, expected 0", acks); end
    first_port = -1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 12 && first_port < 0; i++) begin
      @(posedge clk); #1;
      if (p0.ack) first_port = 0;
      else if (p1.ack) first_port = 1;
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    vectors++;
    if (first_port !== 0) begin errors++; $display("FAIL mid_first_grant: port%0d, expected port0", first_port); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_fixed_prio();
    int a0, a1;
    do_reset();
    a0 = 0; a1 = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    repeat (12) begin
      @(posedge clk); #1;
      if (p0.ack) a0++;
      if (p1.ack) a1++;
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    vectors++;
    if (a0 !== 4) begin errors++; $display("FAIL fixed_ack0: %0d, expected 4", a0); end
    vectors++;
    if (a1 !== 0) begin errors++; $display("FAIL fixed_ack1: %0d, expected 0", a1); end
    vectors++;
    if (both_ack !== 1'b0) begin errors++; $display("FAIL fixed_exclusive_ack: both acks seen=%b, expected 0", both_ack); end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    test_reset();
    test_write_read();
    test_simultaneous();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_fairness();
`endif
    test_isolation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
